// File: rtl/qam16_iq_mapper.sv
// qam16_iq_mapper: Gray-coded 16-QAM symbol to I/Q sample mapper.
//   Sits between the bit-to-symbol packer and the pulse-shaping filter.
//   One-cycle registered latency, one symbol per clock, no backpressure.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (synchronous release)
//   sym_in     4-bit symbol; [3:2] select the I level, [1:0] the Q level
//   sym_valid  sym_in is valid this cycle
//   I_out      signed Q1.11 in-phase sample (holds when no new symbol)
//   Q_out      signed Q1.11 quadrature sample (holds when no new symbol)
//   iq_valid   I_out/Q_out carry a new symbol this cycle
module qam16_iq_mapper #(
  parameter int DATA_WIDTH   = 12,
  parameter int BITS_PER_SYM = 4,
  parameter int LVL1         = 648,
  parameter int LVL3         = 1943
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BITS_PER_SYM-1:0]      sym_in,
  input  logic                         sym_valid,
  output logic signed [DATA_WIDTH-1:0] I_out,
  output logic signed [DATA_WIDTH-1:0] Q_out,
  output logic                         iq_valid
);

  // Elaboration-time parameter sanity checks.
  if (BITS_PER_SYM != 4) begin : g_bad_sym_width
    $error("qam16_iq_mapper: BITS_PER_SYM must be 4");
  end
  if (LVL3 >= (1 << (DATA_WIDTH - 1))) begin : g_bad_lvl3
    $error("qam16_iq_mapper: LVL3 does not fit in signed DATA_WIDTH");
  end
  if ((LVL1 <= 0) || (LVL1 >= LVL3)) begin : g_bad_lvl1
    $error("qam16_iq_mapper: LVL1 must satisfy 0 < LVL1 < LVL3");
  end

  // Constellation levels; negatives are exact two's complement negations.
  localparam logic signed [DATA_WIDTH-1:0] POS1 = DATA_WIDTH'(LVL1);
  localparam logic signed [DATA_WIDTH-1:0] POS3 = DATA_WIDTH'(LVL3);
  localparam logic signed [DATA_WIDTH-1:0] NEG1 = -POS1;
  localparam logic signed [DATA_WIDTH-1:0] NEG3 = -POS3;

  // Per-axis Gray map: 00 -> -L3, 01 -> -L1, 11 -> +L1, 10 -> +L3.
  function automatic logic signed [DATA_WIDTH-1:0] gray_level(input logic [1:0] b);
    logic signed [DATA_WIDTH-1:0] lvl;
    lvl = NEG3;
    case (b)
      2'b00:   lvl = NEG3;
      2'b01:   lvl = NEG1;
      2'b11:   lvl = POS1;
      2'b10:   lvl = POS3;
      default: lvl = NEG3;
    endcase
    return lvl;
  endfunction

  logic signed [DATA_WIDTH-1:0] i_q, i_d;
  logic signed [DATA_WIDTH-1:0] q_q, q_d;
  logic                         valid_q, valid_d;

  // Next-state: load mapped levels on a valid symbol, otherwise hold.
  // sym_in is only looked at under sym_valid so X on an idle bus stays out.
  always_comb begin
    i_d     = i_q;
    q_d     = q_q;
    valid_d = 1'b0;
    if (sym_valid) begin
      i_d     = gray_level(sym_in[3:2]);
      q_d     = gray_level(sym_in[1:0]);
      valid_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      i_q     <= i_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign I_out    = i_q;
  assign Q_out    = q_q;
  assign iq_valid = valid_q;

endmodule

// File: tb/tb_qam16_iq_mapper.sv
// Self-checking bench for qam16_iq_mapper with a scoreboard of expected I/Q.
module tb_qam16_iq_mapper;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          sym_in;
  logic                sym_valid;
  logic signed [W-1:0] I_out;
  logic signed [W-1:0] Q_out;
  logic                iq_valid;

  typedef struct {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  qam16_iq_mapper dut (
    .clk      (clk),
    .rst      (rst),
    .sym_in   (sym_in),
    .sym_valid(sym_valid),
    .I_out    (I_out),
    .Q_out    (Q_out),
    .iq_valid (iq_valid)
  );

  always #5 clk = ~clk;

  // Reference Gray levels, written straight from the constellation table.
  function automatic logic signed [W-1:0] ref_level(input logic [1:0] b);
    case (b)
      2'b00:   return -12'sd1943;
      2'b01:   return -12'sd648;
      2'b11:   return 12'sd648;
      default: return 12'sd1943;
    endcase
  endfunction

  function automatic exp_t ref_map(input logic [3:0] s);
    exp_t e;
    e.i = ref_level(s[3:2]);
    e.q = ref_level(s[1:0]);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; sym_valid = 1'b1; sym_in = 4'hF;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if ((I_out !== 12'sd0) || (Q_out !== 12'sd0) || (iq_valid !== 1'b0)) begin
        failures++;
        $display("FAIL reset: I=%0d Q=%0d v=%b required 0 0 0", I_out, Q_out, iq_valid);
      end
    end
    // Release with sym_valid already high: captured on first edge after release.
    @(negedge clk);
    rst = 1'b0; sym_in = 4'hF; sym_valid = 1'b1;
    sb.push_back(ref_map(4'hF));
    @(posedge clk); #1;
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ((iq_valid !== 1'b1) || (I_out !== e.i) || (Q_out !== e.q)) begin
        failures++;
        $display("FAIL reset_release: v=%b I=%0d Q=%0d required 1 %0d %0d", iq_valid, I_out, Q_out, e.i, e.q);
      end
    end
    @(negedge clk); sym_valid = 1'b0;
  endtask

  task automatic test_truth_table();
    for (int s = 0; s < 16; s++) begin
      exp_t e;
      @(negedge clk);
      sym_valid = 1'b1; sym_in = 4'(s);
      sb.push_back(ref_map(4'(s)));
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL truth_table: scoreboard empty at s=%0d", s);
      end else begin
        e = sb.pop_front();
        if ((iq_valid !== 1'b1) || (I_out !== e.i) || (Q_out !== e.q)) begin
          failures++;
          $display("FAIL truth_table s=%0d: v=%b I=%0d Q=%0d required 1 %0d %0d", s, iq_valid, I_out, Q_out, e.i, e.q);
        end
      end
      // Idle cycle with X on sym_in: outputs must hold, valid drop.
      @(negedge clk);
      sym_valid = 1'b0; sym_in = 4'bxxxx;
      @(posedge clk); #1;
      checks++;
      if ((iq_valid !== 1'b0) || (I_out !== e.i) || (Q_out !== e.q)) begin
        failures++;
        $display("FAIL idle_x s=%0d: v=%b I=%0d Q=%0d required 0 %0d %0d", s, iq_valid, I_out, Q_out, e.i, e.q);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    @(negedge clk);
    sym_valid = 1'b1; sym_in = 4'b1010;
    sb.push_back(ref_map(4'b1010));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ((iq_valid !== 1'b1) || (I_out !== 12'sd1943) || (Q_out !== 12'sd1943)) begin
      failures++;
      $display("FAIL hold_load: v=%b I=%0d Q=%0d required 1 1943 1943", iq_valid, I_out, Q_out);
    end
    @(negedge clk);
    sym_valid = 1'b0; sym_in = 4'b0000;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ((iq_valid !== 1'b0) || (I_out !== e.i) || (Q_out !== e.q)) begin
        failures++;
        $display("FAIL hold: v=%b I=%0d Q=%0d required 0 %0d %0d", iq_valid, I_out, Q_out, e.i, e.q);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      sym_valid = 1'b1; sym_in = 4'(s);
      sb.push_back(ref_map(4'(s)));
      @(posedge clk); #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL back_to_back: scoreboard empty at s=%0d", s);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((iq_valid !== 1'b1) || (I_out !== e.i) || (Q_out !== e.q)) begin
          failures++;
          $display("FAIL back_to_back s=%0d: v=%b I=%0d Q=%0d required 1 %0d %0d", s, iq_valid, I_out, Q_out, e.i, e.q);
        end
      end
    end
    @(negedge clk); sym_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (iq_valid !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_end: v=%b required 0", iq_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sym_valid = 1'b1; sym_in = 4'b0110;
    sb.push_back(ref_map(4'b0110));
    @(posedge clk); #1;
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ((iq_valid !== 1'b1) || (I_out !== e.i) || (Q_out !== e.q)) begin
        failures++;
        $display("FAIL async_pre: v=%b I=%0d Q=%0d required 1 %0d %0d", iq_valid, I_out, Q_out, e.i, e.q);
      end
    end
    // Next symbol is in flight when reset hits between edges; it is discarded.
    @(negedge clk);
    sym_in = 4'b1001;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ((I_out !== 12'sd0) || (Q_out !== 12'sd0) || (iq_valid !== 1'b0)) begin
      failures++;
      $display("FAIL async_reset: I=%0d Q=%0d v=%b required 0 0 0 before edge", I_out, Q_out, iq_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ((I_out !== 12'sd0) || (Q_out !== 12'sd0) || (iq_valid !== 1'b0)) begin
      failures++;
      $display("FAIL async_reset_hold: I=%0d Q=%0d v=%b required 0 0 0", I_out, Q_out, iq_valid);
    end
    @(negedge clk);
    rst = 1'b0; sym_valid = 1'b1; sym_in = 4'b1011;
    sb.push_back(ref_map(4'b1011));
    @(posedge clk); #1;
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ((iq_valid !== 1'b1) || (I_out !== 12'sd1943) || (Q_out !== 12'sd648) || (I_out !== e.i) || (Q_out !== e.q)) begin
        failures++;
        $display("FAIL async_after: v=%b I=%0d Q=%0d required 1 1943 648", iq_valid, I_out, Q_out);
      end
    end
    @(negedge clk); sym_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ((iq_valid !== 1'b0) || (sb.size() != 0)) begin
      failures++;
      $display("FAIL async_end: v=%b pending=%0d required 0 0", iq_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qam16_iq_mapper.md
Name: qam16_iq_mapper

Overview:
- Maps 4-bit symbols to 16-QAM I/Q baseband samples with Gray coding.
- Bits [3:2] select the I level; bits [1:0] select the Q level.
- Sits in the modem TX path, between the bit-to-symbol packer and the pulse-shaping filter.
- Registered output, one-cycle latency, valid-qualified streaming.

Parameters:
- DATA_WIDTH, 12: signed sample width, two's complement, Q1.11 format.
- BITS_PER_SYM, 4: symbol width. Fixed at 4; any other value is an elaboration error.
- LVL1, 648: magnitude of the inner level, round(0.3162·2048), unit-average-energy constellation.
- LVL3, 1943: magnitude of the outer level, round(0.9487·2048).

Ports:
- clk, input, 1: system clock (27 MHz nominal).
- rst, input, 1: asynchronous active-high reset.
- sym_in, input, BITS_PER_SYM: symbol, MSB first.
- sym_valid, input, 1: sym_in is valid this cycle.
- I_out, output, DATA_WIDTH (signed): in-phase sample.
- Q_out, output, DATA_WIDTH (signed): quadrature sample.
- iq_valid, output, 1: I_out/Q_out carry a new symbol this cycle.

Behaviour:
- Reset: while rst=1, asynchronously force I_out=0, Q_out=0, iq_valid=0. Release is synchronous to clk; the first symbol can be accepted on the first clk edge after deassertion.
- Gray map, applied identically per axis to a 2-bit field b:
  - 00 -> -LVL3
  - 01 -> -LVL1
  - 11 -> +LVL1
  - 10 -> +LVL3
- I uses sym_in[3:2]; Q uses sym_in[1:0].
- On a rising clk edge with sym_valid=1: I_out/Q_out load the mapped levels; iq_valid becomes 1.
- On a rising clk edge with sym_valid=0: iq_valid becomes 0; I_out/Q_out hold their previous values (no return to zero).
- Latency: exactly one clock from sym_valid/sym_in sampled to I_out/Q_out/iq_valid updated.
- Throughput: one symbol per clock. Back-to-back valid symbols produce back-to-back iq_valid pulses.
- No backpressure. The block always accepts input.
- The mapping is purely combinational into the output registers. No state beyond the three output registers.
- Arithmetic:
  - Levels are constants sign-extended to DATA_WIDTH.
  - Negative levels are exact two's complement negations.
  - No saturation is needed.
  - Elaboration must check LVL3 < 2^(DATA_WIDTH-1).
- sym_in is ignored when sym_valid=0; X on sym_in with sym_valid=0 must not propagate to the outputs.
- Reset asserted mid-stream: outputs go to zero immediately, without waiting for a clock edge. The symbol in flight is discarded.
- Reset deasserted with sym_valid=1 already high: the symbol is captured on the first edge after release.

Test Plan:
1. Reset: hold rst=1 for 5 cycles with sym_valid=1, sym_in=4'hF -> I_out=0, Q_out=0, iq_valid=0 throughout.
2. Truth table: drive each s=0..15 as a single-cycle valid pulse -> one cycle later iq_valid=1 with:
   - s=0000: I=-1943, Q=-1943
   - s=0101: I=-648, Q=-648
   - s=1111: I=+648, Q=+648
   - s=1010: I=+1943, Q=+1943
   - s=0110: I=-648, Q=+1943
   - s=1001: I=+1943, Q=-648
   - all 16 combinations checked.
3. Hold: after sym=1010 with valid, drop sym_valid and change sym_in to 0000 -> iq_valid=0 next cycle; I/Q stay at +1943/+1943.
4. Streaming: 16 consecutive valid symbols 0..15 -> 16 consecutive iq_valid=1 cycles; outputs match the table in order with 1-cycle lag.
5. Async reset mid-stream: assert rst between clock edges during streaming -> outputs zero before the next edge. After release, the next valid symbol 1011 gives I=+1943, Q=+648.
